// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
// Single-entry registered response buffer with valid/ready backpressure and per-port accept counters.
module alu_share_arbiter #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_aluc,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_aluc,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_aluc,
    input  logic [31:0]      alu_r,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_port,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_r,
    output logic [3:0]       resp_flags,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             rr_last_q;
    logic             run_q;
    logic             slot_free;
    logic             any_req;
    logic             grant;
    logic             accept0;
    logic             accept1;
    logic             accept;
    logic             resp_port_q;
    logic [TAG_W-1:0] resp_tag_q;
    logic [31:0]      resp_r_q;
    logic [3:0]       resp_flags_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // run_q keeps both readies low until the first edge seen with reset released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_comb begin
        any_req = req0_valid | req1_valid;
        grant   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~rr_last_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign slot_free  = (state_q == ST_EMPTY) | resp_ready;
    assign req0_ready = slot_free & any_req & ~grant & rst_n & run_q;
    assign req1_ready = slot_free & any_req &  grant & rst_n & run_q;
    assign accept0    = req0_valid & req0_ready;
    assign accept1    = req1_valid & req1_ready;
    assign accept     = accept0 | accept1;

    // With no request the mux falls back to port 0 so the ALU inputs stay deterministic.
    always_comb begin
        alu_a    = req0_a;
        alu_b    = req0_b;
        alu_aluc = req0_aluc;
        if (any_req && grant) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_aluc = req1_aluc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (resp_ready && !accept) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Payload only moves on accept, so a drain leaves the last response readable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q    <= 1'b1;
            resp_port_q  <= 1'b0;
            resp_tag_q   <= '0;
            resp_r_q     <= '0;
            resp_flags_q <= '0;
        end else if (accept) begin
            rr_last_q    <= accept1;
            resp_port_q  <= accept1;
            resp_tag_q   <= accept1 ? req1_tag : req0_tag;
            resp_r_q     <= alu_r;
            resp_flags_q <= {alu_zero, alu_carry, alu_negative, alu_overflow};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (accept0) begin
                cnt0_q <= cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (accept1) begin
                cnt1_q <= cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign resp_valid = (state_q == ST_FULL);
    assign resp_port  = resp_port_q;
    assign resp_tag   = resp_tag_q;
    assign resp_r     = resp_r_q;
    assign resp_flags = resp_flags_q;
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - bench for alu_share_arbiter
// Behavioural ALU plus a transaction-level reference of grant, response buffer and counters.
module tb_alu_share_arbiter;

    localparam int TAG_W = 4;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic [3:0]       req0_aluc, req1_aluc;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic [31:0]      alu_a, alu_b, alu_r;
    logic [3:0]       alu_aluc;
    logic             alu_zero, alu_carry, alu_negative, alu_overflow;
    logic             resp_valid, resp_ready, resp_port;
    logic [TAG_W-1:0] resp_tag;
    logic [31:0]      resp_r;
    logic [3:0]       resp_flags;
    logic [CNT_W-1:0] cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    logic             m_valid, m_port, m_last;
    logic [TAG_W-1:0] m_tag;
    logic [31:0]      m_r;
    logic [3:0]       m_flags;
    logic [CNT_W-1:0] m_cnt [2];
    logic             acc0, acc1;

    alu_share_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_aluc(req0_aluc), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_aluc(req1_aluc), .req1_tag(req1_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_port(resp_port),
        .resp_tag(resp_tag), .resp_r(resp_r), .resp_flags(resp_flags),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {r, zero, carry, negative, overflow}; compares report their result on negative.
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v, n;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
            4'b0010: begin
                s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0001: begin r = a - b; c = (a < b); end
            4'b0011: begin
                r = a - b; c = (a < b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            4'b0111: r = ~(a | b);
            4'b1010: r = {31'b0, (a < b)};
            4'b1011: r = {31'b0, ($signed(a) < $signed(b))};
            4'b1100: r = $signed(b) >>> a[4:0];
            4'b1101: r = b >> a[4:0];
            4'b1110, 4'b1111: r = b << a[4:0];
            default: r = a + b;
        endcase
        n = (op == 4'b1010 || op == 4'b1011) ? r[0] : r[31];
        return {r, (r == 32'd0), c, n, v};
    endfunction

    assign {alu_r, alu_zero, alu_carry, alu_negative, alu_overflow} = alu_model(alu_a, alu_b, alu_aluc);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_port = 1'b0; m_last = 1'b1; m_tag = '0;
        m_r = '0; m_flags = '0; m_cnt[0] = '0; m_cnt[1] = '0;
        acc0 = 1'b0; acc1 = 1'b0;
    endtask

    // Entered and left at posedge+1; readies and ALU drive are judged at the negedge.
    task automatic cycle();
        logic        sf, hg, g;
        logic [35:0] res;
        @(negedge clk);
        sf   = !m_valid || resp_ready;
        hg   = req0_valid || req1_valid;
        g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
        acc0 = sf && hg && !g;
        acc1 = sf && hg && g;
        check("req0_ready", req0_ready, acc0);
        check("req1_ready", req1_ready, acc1);
        check("alu_a", alu_a, (hg && g) ? req1_a : req0_a);
        check("alu_b", alu_b, (hg && g) ? req1_b : req0_b);
        check("alu_aluc", alu_aluc, (hg && g) ? req1_aluc : req0_aluc);
        @(posedge clk);
        #1;
        if (acc0 || acc1) begin
            res     = acc1 ? alu_model(req1_a, req1_b, req1_aluc) : alu_model(req0_a, req0_b, req0_aluc);
            m_valid = 1'b1;
            m_port  = acc1;
            m_tag   = acc1 ? req1_tag : req0_tag;
            m_r     = res[35:4];
            m_flags = res[3:0];
            m_last  = acc1;
            m_cnt[acc1] = m_cnt[acc1] + 1'b1;
        end else if (m_valid && resp_ready) begin
            m_valid = 1'b0;
        end
        check("resp_valid", resp_valid, m_valid);
        check("resp_port", resp_port, m_port);
        check("resp_tag", resp_tag, m_tag);
        check("resp_r", resp_r, m_r);
        check("resp_flags", resp_flags, m_flags);
        check("cnt0", cnt0, m_cnt[0]);
        check("cnt1", cnt1, m_cnt[1]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_async_valid", resp_valid, 1'b0);
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_ready1", req1_ready, 1'b0);
        @(posedge clk);
        #1;
        model_reset();
        check("rst_port", resp_port, 1'b0);
        check("rst_tag", resp_tag, '0);
        check("rst_r", resp_r, '0);
        check("rst_flags", resp_flags, '0);
        check("rst_cnt0", cnt0, '0);
        check("rst_cnt1", cnt1, '0);
        rst_n = 1'b1;
        #1;
        check("release_ready0", req0_ready, 1'b0);
        check("release_ready1", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; resp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_aluc = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_aluc = '0; req1_tag = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // port 0 alone: signed add 5 + 3
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_aluc = 4'b0010; req0_tag = 4'd7;
        resp_ready = 1'b1;
        cycle();
        check("t1_valid", resp_valid, 1'b1);
        check("t1_r", resp_r, 32'd8);
        check("t1_port", resp_port, 1'b0);
        check("t1_tag", resp_tag, 4'd7);
        check("t1_flags", resp_flags, 4'b0000);
        check("t1_cnt0", cnt0, 16'd1);
        req0_valid = 1'b0;

        // both ports valid: alternation starts with port 0 after reset
        do_reset();
        req0_valid = 1'b1; req0_a = 32'hF0F0_1234; req0_b = 32'h0FF0_FFFF; req0_aluc = 4'b0100; req0_tag = 4'd3;
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_aluc = 4'b1011; req1_tag = 4'd9;
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("rr_order", resp_port, k[0]);
            if (k[0]) begin
                check("slt_r", resp_r, 32'd1);
                check("slt_neg", resp_flags[1], 1'b1);
            end else begin
                check("and_r", resp_r, 32'h00F0_1234);
            end
        end
        check("rr_cnt0", cnt0, 16'd2);
        check("rr_cnt1", cnt1, 16'd2);

        // backpressure: port 0 fills the buffer, then both wait three cycles
        req1_valid = 1'b0;
        cycle();
        resp_ready = 1'b0;
        req1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_readies", {req0_ready, req1_ready}, 2'b00);
            check("bp_port", resp_port, 1'b0);
            check("bp_r", resp_r, 32'h00F0_1234);
            check("bp_cnt0", cnt0, 16'd3);
        end
        resp_ready = 1'b1;
        #1;
        check("bp_rel_ready1", req1_ready, 1'b1);
        check("bp_rel_ready0", req0_ready, 1'b0);
        cycle();
        check("bp_rel_valid", resp_valid, 1'b1);
        check("bp_rel_port", resp_port, 1'b1);
        check("bp_rel_cnt1", cnt1, 16'd3);

        // signed overflow on port 1
        req0_valid = 1'b0;
        req1_a = 32'h7FFF_FFFF; req1_b = 32'd1; req1_aluc = 4'b0010; req1_tag = 4'd5;
        cycle();
        check("ovf_r", resp_r, 32'h8000_0000);
        check("ovf_flags", resp_flags, 4'b0011);
        check("ovf_tag", resp_tag, 4'd5);
        req1_valid = 1'b0;

        // randomized traffic; a waiting requester keeps its valid and payload
        acc0 = 1'b0; acc1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!(req0_valid && !acc0)) begin
                req0_valid = ($urandom_range(0, 99) < 60);
                req0_a = $urandom; req0_b = $urandom;
                req0_aluc = 4'($urandom_range(0, 15)); req0_tag = 4'($urandom_range(0, 15));
            end
            if (!(req1_valid && !acc1)) begin
                req1_valid = ($urandom_range(0, 99) < 60);
                req1_a = $urandom; req1_b = $urandom;
                req1_aluc = 4'($urandom_range(0, 15)); req1_tag = 4'($urandom_range(0, 15));
            end
            resp_ready = ($urandom_range(0, 99) < 70);
            cycle();
        end

        // reset while a response is pending
        req0_valid = 1'b1; req1_valid = 1'b0; resp_ready = 1'b1;
        cycle();
        resp_ready = 1'b0;
        req0_valid = 1'b0;
        check("pre_reset_valid", resp_valid, 1'b1);
        do_reset();

        // counter wrap on port 0
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_aluc = 4'b0000;
        req1_valid = 1'b0; resp_ready = 1'b1;
        repeat ((1 << CNT_W) - 1) @(posedge clk);
        #1;
        check("wrap_max", cnt0, 16'hFFFF);
        @(posedge clk);
        #1;
        check("wrap_zero", cnt0, 16'h0000);
        check("wrap_cnt1", cnt1, 16'h0000);
        req0_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance between two requesters, port 0 (integer pipe EX) and port 1 (address/branch helper).
- Arbitrates round-robin, drives the ALU operand and opcode inputs, and registers the result and flags into a single-entry response buffer with valid/ready backpressure.
- Keeps a wrapping per-port count of accepted operations for debug.

Parameters:
- TAG_W, 4, width of the per-request tag returned with the result.
- CNT_W, 16, width of the per-port accepted-operation counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle when valid & ready.
- req0_a  in  32  port 0 operand a (shift amount for shift ops).
- req0_b  in  32  port 0 operand b.
- req0_aluc  in  4  port 0 ALU opcode, passed through unchanged.
- req0_tag  in  TAG_W  port 0 tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_aluc, req1_tag: same as port 0, for port 1.
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- alu_aluc  out  4  to ALU aluc.
- alu_r  in  32  ALU result.
- alu_zero, alu_carry, alu_negative, alu_overflow  in  1 each  ALU flags.
- resp_valid  out  1  response buffer holds a result.
- resp_ready  in  1  consumer takes the response when valid & ready.
- resp_port  out  1  requester that issued the response (0 or 1).
- resp_tag  out  TAG_W  tag of that request.
- resp_r  out  32  registered result.
- resp_flags  out  4  {zero, carry, negative, overflow}, registered.
- cnt0, cnt1  out  CNT_W each  accepted-operation counters.

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - resp_valid, resp_port, resp_tag, resp_r, resp_flags, cnt0 and cnt1 all go to 0.
  - Round-robin pointer rr_last goes to 1, so port 0 wins the first conflict.
  - req0_ready and req1_ready are 0 while reset is asserted.
- Slot availability: slot_free = !resp_valid | resp_ready. The response buffer is a pass-through register, so a response drain and a new accept can happen in the same cycle.
- Grant, combinational within the cycle:
  - Only port 0 valid: grant port 0.
  - Only port 1 valid: grant port 1.
  - Both valid: grant the port != rr_last.
  - Neither valid: no grant.
  - reqX_ready = slot_free & (grant == X) & rst_n. The ready of a non-granted port is 0.
  - Readies may depend on valids; valids must not depend on readies.
- ALU drive:
  - alu_a, alu_b and alu_aluc are muxed from the granted port.
  - With no grant they hold the port 0 inputs. Don't care, but they must be deterministic, with no latch inferred.
- Accept, on the clock edge when some reqX_valid & reqX_ready:
  - Load resp_r and resp_flags from the ALU outputs.
  - Load resp_port = X and resp_tag = reqX_tag.
  - Set resp_valid = 1, rr_last = X and cntX = cntX + 1, wrapping modulo 2^CNT_W.
- Latency: accept in cycle N puts the response visible in cycle N+1. Throughput is one op per cycle while resp_ready = 1.
- Drain: when resp_valid & resp_ready and no accept that cycle, resp_valid goes to 0. The data fields hold their last values.
- Backpressure: with resp_valid = 1 and resp_ready = 0:
  - Both readies are 0 and all response fields are frozen.
  - rr_last does not move, and requesters must hold their valid and payload stable.
- Flags are sampled exactly as the ALU presents them. The ALU holds carry/overflow from its last op that updated them; this block does not mask or recompute flags.
- Fairness: with both ports continuously valid and resp_ready = 1, grants alternate 0,1,0,1... No port waits more than one accepted op of the other port.
- Reset mid-operation: a pending response is discarded, counters are cleared, and no partial ready is asserted after reset release until the first clk edge with rst_n high.
- Single FSM view: EMPTY (resp_valid = 0) and FULL (resp_valid = 1).
  - EMPTY goes to FULL on accept.
  - FULL stays FULL on accept or stall.
  - FULL goes to EMPTY on drain without accept.

Test Plan:
- Reset, then port 0 only: a = 5, b = 3, aluc = 0010 (signed add), tag = 7 -> req0_ready = 1 same cycle; next cycle resp_valid = 1, resp_r = 8, resp_port = 0, resp_tag = 7, resp_flags = 0000, cnt0 = 1.
- Both ports valid for 4 cycles, resp_ready = 1, port 0 and 1 ops: 0100 (and), 1011 (slt) -> grant order 0,1,0,1; cnt0 = 2, cnt1 = 2.
  - Port 1 slt with a = -1, b = 1 -> resp_r = 1, negative flag = 1.
- Backpressure: fill the buffer, hold resp_ready = 0 for 3 cycles with both valid -> both readies 0, resp fields frozen, rr_last unchanged.
  - Then raise resp_ready -> drain and new accept in the same cycle, resp_valid stays 1.
- Overflow flag: port 1, a = 0x7FFFFFFF, b = 1, aluc = 0010 -> resp_r = 0x80000000, resp_flags = 0011 (negative, overflow).
- Counter wrap: force 2^CNT_W accepts on port 0 -> cnt0 returns to 0.
  - Separately, assert rst_n low while resp_valid = 1 -> resp_valid drops immediately, without waiting for a clock edge.
